mem_stage_ls: RTL and testbench

//  Next-generation MEM stage of the 5-stage MIPS pipeline, between EX/MEM and WB.

---
 rtl/mem_stage_ls_pkg.sv | 48 ++++
 rtl/mem_stage_ls_if.sv | 40 ++++
 rtl/mem_stage_ls_dmem_be.sv | 22 ++
 rtl/mem_stage_ls.sv | 118 +++++++++++
 tb/tb_mem_stage_ls.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_ls_pkg.sv
// rtl/mem_stage_ls_pkg.sv - size encodings, FSM states and lane helpers for the MEM stage
package mem_stage_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Reserved size 2'b11 falls into the word cases everywhere below.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    return ((size == SIZE_H) && a[0]) || (size[1] && (a != 2'b00));
  endfunction

  function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SIZE_B:  return 4'b0001 << a;
      SIZE_H:  return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the low bytes so whichever lanes are enabled see the right data.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SIZE_B:  return {4{wd[7:0]}};
      SIZE_H:  return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] a, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_B:  return uns ? {24'd0, b} : {{24{b[7]}}, b};
      SIZE_H:  return uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_ls_if.sv
// rtl/mem_stage_ls_if.sv - EX/MEM inputs, stall/branch feedback and MEM/WB outputs
interface mem_stage_ls_if #(
  parameter int REG_W = 5,
  parameter int WBC_W = 2
);
  logic             in_valid;
  logic [31:0]      alu_result;
  logic [31:0]      write_data;
  logic [REG_W-1:0] write_reg;
  logic [WBC_W-1:0] wb_control;
  logic             mem_read;
  logic             mem_write;
  logic [1:0]       mem_size;
  logic             mem_unsigned;
  logic             branch;
  logic             branch_ne;
  logic             zero;
  logic             stall;
  logic             pc_src;
  logic [31:0]      read_data_out;
  logic [31:0]      alu_result_out;
  logic [REG_W-1:0] write_reg_out;
  logic [WBC_W-1:0] wb_control_out;
  logic             wb_valid_out;
  logic             misaligned_out;

  modport master (
    output in_valid, alu_result, write_data, write_reg, wb_control, mem_read, mem_write,
           mem_size, mem_unsigned, branch, branch_ne, zero,
    input  stall, pc_src, read_data_out, alu_result_out, write_reg_out, wb_control_out,
           wb_valid_out, misaligned_out
  );

  modport slave (
    input  in_valid, alu_result, write_data, write_reg, wb_control, mem_read, mem_write,
           mem_size, mem_unsigned, branch, branch_ne, zero,
    output stall, pc_src, read_data_out, alu_result_out, write_reg_out, wb_control_out,
           wb_valid_out, misaligned_out
  );
endinterface

// File: rtl/mem_stage_ls_dmem_be.sv
// rtl/mem_stage_ls_dmem_be.sv - word-wide data memory with per-byte write enables
module dmem_be #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH];

  // Byte-lane write; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/mem_stage_ls.sv
// rtl/mem_stage_ls.sv - MEM stage with sub-word access, latency stall, branch resolve and MEM/WB latch
module mem_stage_ls
  import mem_stage_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int MEM_LATENCY = 1,
  parameter int REG_W       = 5,
  parameter int WBC_W       = 2
) (
  input logic           clk,
  input logic           rst,
  mem_stage_ls_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_mem, fault, acc, done, stall;
  logic [3:0]       we;
  logic [31:0]      rword, load_data;
  logic [31:0]      rd_q, alu_q;
  logic [REG_W-1:0] wreg_q;
  logic [WBC_W-1:0] wbc_q;
  logic             wbv_q, mis_q;

  assign is_mem = bus.in_valid & (bus.mem_read | bus.mem_write);
  assign fault  = is_mem & is_misaligned(bus.mem_size, bus.alu_result[1:0]);
  assign acc    = is_mem & ~fault;

  // Latency sequencing: hold upstream until the access reaches its completing cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc) begin
          if (MEM_LATENCY > 1) begin
            state_d = ST_BUSY;
            cnt_d   = CW'(MEM_LATENCY - 2);
            stall   = 1'b1;
          end else begin
            done = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          stall = 1'b1;
          cnt_d = cnt_q - CW'(1);
        end else begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // FSM state and wait counter; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Writes are gated by reset so a held store cannot commit while reset is low.
  assign we = (done & bus.mem_write & rst) ? lane_en(bus.mem_size, bus.alu_result[1:0]) : 4'b0000;

  dmem_be #(.DEPTH(DEPTH)) u_dmem (
    .clk     (clk),
    .addr_i  (bus.alu_result[AW+1:2]),
    .we_i    (we),
    .wdata_i (store_data(bus.mem_size, bus.write_data)),
    .rdata_o (rword)
  );

  // A simultaneous read/write behaves as a store, so no load data is returned.
  assign load_data = (done & bus.mem_read & ~bus.mem_write)
                   ? load_extract(rword, bus.mem_size, bus.alu_result[1:0], bus.mem_unsigned)
                   : 32'd0;

  // MEM/WB latch: bubble while stalled, otherwise capture the completed instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q   <= '0;
      alu_q  <= '0;
      wreg_q <= '0;
      wbc_q  <= '0;
      wbv_q  <= 1'b0;
      mis_q  <= 1'b0;
    end else if (stall) begin
      wbv_q <= 1'b0;
      wbc_q <= '0;
    end else begin
      rd_q   <= load_data;
      alu_q  <= bus.alu_result;
      wreg_q <= bus.write_reg;
      wbc_q  <= (bus.in_valid & ~fault) ? bus.wb_control : '0;
      wbv_q  <= bus.in_valid;
      mis_q  <= fault;
    end
  end

  assign bus.stall          = stall;
  assign bus.pc_src         = bus.in_valid & bus.branch & (bus.zero ^ bus.branch_ne) & ~stall;
  assign bus.read_data_out  = rd_q;
  assign bus.alu_result_out = alu_q;
  assign bus.write_reg_out  = wreg_q;
  assign bus.wb_control_out = wbc_q;
  assign bus.wb_valid_out   = wbv_q;
  assign bus.misaligned_out = mis_q;
endmodule

// File: tb/tb_mem_stage_ls.sv
// tb/tb_mem_stage_ls.sv - self-checking bench for mem_stage_ls at latencies 1, 3 and 4
module tb_mem_stage_ls;
  localparam int DEPTH = 1024;

  typedef struct {
    bit          v, rd, wr;
    logic [1:0]  sz;
    bit          uns, br, bne, z;
    logic [31:0] a, wd;
    logic [4:0]  wreg;
    logic [1:0]  wbc;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] sel = 2'd0;

  logic        t_v = 0, t_rd = 0, t_wr = 0, t_uns = 0, t_br = 0, t_bne = 0, t_z = 0;
  logic [1:0]  t_sz = 0, t_wbc = 0;
  logic [31:0] t_a = 0, t_wd = 0;
  logic [4:0]  t_wreg = 0;

  logic        stall_s, pc_s, wbv_s, mis_s;
  logic [31:0] rd_s, alu_s;
  logic [4:0]  wreg_s;
  logic [1:0]  wbc_s;

  logic        e_stall = 0, e_pc = 0, e_wbv = 0, e_mis = 0;
  logic [31:0] e_rd = 0, e_alu = 0;
  logic [4:0]  e_wreg = 0;
  logic [1:0]  e_wbc = 0;

  bit chk_en = 0;
  int n_chk = 0, n_fail = 0, stall_cnt = 0, bub_cnt = 0;
  logic [31:0] mm [int];

  always #5 clk = ~clk;

  mem_stage_ls_if bus0 ();
  mem_stage_ls_if bus1 ();
  mem_stage_ls_if bus2 ();

  assign bus0.in_valid = t_v & (sel == 2'd0);
  assign bus1.in_valid = t_v & (sel == 2'd1);
  assign bus2.in_valid = t_v & (sel == 2'd2);
  assign {bus0.alu_result, bus0.write_data, bus0.write_reg, bus0.wb_control, bus0.mem_read, bus0.mem_write,
          bus0.mem_size, bus0.mem_unsigned, bus0.branch, bus0.branch_ne, bus0.zero}
       = {t_a, t_wd, t_wreg, t_wbc, t_rd, t_wr, t_sz, t_uns, t_br, t_bne, t_z};
  assign {bus1.alu_result, bus1.write_data, bus1.write_reg, bus1.wb_control, bus1.mem_read, bus1.mem_write,
          bus1.mem_size, bus1.mem_unsigned, bus1.branch, bus1.branch_ne, bus1.zero}
       = {t_a, t_wd, t_wreg, t_wbc, t_rd, t_wr, t_sz, t_uns, t_br, t_bne, t_z};
  assign {bus2.alu_result, bus2.write_data, bus2.write_reg, bus2.wb_control, bus2.mem_read, bus2.mem_write,
          bus2.mem_size, bus2.mem_unsigned, bus2.branch, bus2.branch_ne, bus2.zero}
       = {t_a, t_wd, t_wreg, t_wbc, t_rd, t_wr, t_sz, t_uns, t_br, t_bne, t_z};

  mem_stage_ls #(.MEM_LATENCY(1)) u_dut0 (.clk(clk), .rst(rst_n), .bus(bus0.slave));
  mem_stage_ls #(.MEM_LATENCY(3)) u_dut1 (.clk(clk), .rst(rst_n), .bus(bus1.slave));
  mem_stage_ls #(.MEM_LATENCY(4)) u_dut2 (.clk(clk), .rst(rst_n), .bus(bus2.slave));

  always_comb begin
    case (sel)
      2'd0: {stall_s, pc_s, rd_s, alu_s, wreg_s, wbc_s, wbv_s, mis_s} =
            {bus0.stall, bus0.pc_src, bus0.read_data_out, bus0.alu_result_out, bus0.write_reg_out,
             bus0.wb_control_out, bus0.wb_valid_out, bus0.misaligned_out};
      2'd1: {stall_s, pc_s, rd_s, alu_s, wreg_s, wbc_s, wbv_s, mis_s} =
            {bus1.stall, bus1.pc_src, bus1.read_data_out, bus1.alu_result_out, bus1.write_reg_out,
             bus1.wb_control_out, bus1.wb_valid_out, bus1.misaligned_out};
      default: {stall_s, pc_s, rd_s, alu_s, wreg_s, wbc_s, wbv_s, mis_s} =
            {bus2.stall, bus2.pc_src, bus2.read_data_out, bus2.alu_result_out, bus2.write_reg_out,
             bus2.wb_control_out, bus2.wb_valid_out, bus2.misaligned_out};
    endcase
  end

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, req, $time);
    end
  endfunction

  // Model helpers: plain byte arithmetic on a word-addressed array.
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int lat_of(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 3 : 4;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] w, input logic [1:0] sz, input bit uns,
                                           input logic [31:0] a);
    int n;
    longint v;
    n = nbytes(sz);
    v = longint'(w >> (8 * (a % 4))) & ((64'sd1 <<< (8 * n)) - 1);
    if (!uns && v >= (64'sd1 <<< (8 * n - 1))) v = v - (64'sd1 <<< (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] mdl_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [31:0] a, input logic [31:0] wd);
    int lane;
    lane = int'(a % 4);
    for (int i = 0; i < nbytes(sz); i++) w[8*(lane+i) +: 8] = wd[8*i +: 8];
    return w;
  endfunction

  function automatic op_t mop(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                              input logic [31:0] a, input logic [31:0] wd);
    op_t o;
    o.v = 1; o.rd = rd; o.wr = wr; o.sz = sz; o.uns = uns;
    o.br = 0; o.bne = 0; o.z = 0; o.a = a; o.wd = wd;
    o.wreg = 5'd9; o.wbc = {rd, rd};
    return o;
  endfunction

  function automatic op_t bop(input bit v, input bit bne, input bit z);
    op_t o;
    o = mop(0, 0, 2'd2, 0, 32'h100, 32'd0);
    o.v = v; o.br = 1; o.bne = bne; o.z = z; o.wreg = 5'd3; o.wbc = 2'b10;
    return o;
  endfunction

  task automatic drive(input op_t o);
    t_v = o.v; t_rd = o.rd; t_wr = o.wr; t_sz = o.sz; t_uns = o.uns;
    t_br = o.br; t_bne = o.bne; t_z = o.z; t_a = o.a; t_wd = o.wd; t_wreg = o.wreg; t_wbc = o.wbc;
  endtask

  // Drop in_valid for one edge and restart the model from the resulting idle outputs.
  task automatic resync();
    chk_en = 0;
    t_v = 0;
    @(posedge clk); #1;
    e_stall = 0; e_pc = 0; e_rd = 0; e_alu = t_a; e_wreg = t_wreg; e_wbc = 0; e_wbv = 0; e_mis = 0;
    chk_en = 1;
  endtask

  // One instruction: latency-1 stall cycles with bubbles, then the completing edge.
  task automatic run_op(input op_t o);
    bit mis, acc;
    int nst, key;
    logic [31:0] w, rdv;
    drive(o);
    mis = o.v && (o.rd || o.wr) && ((o.a % nbytes(o.sz)) != 0);
    acc = o.v && (o.rd || o.wr) && !mis;
    nst = acc ? lat_of(sel) - 1 : 0;
    for (int k = 0; k < nst; k++) begin
      e_stall = 1; e_pc = 0;
      @(posedge clk); #1;
      e_wbv = 0; e_wbc = 0;
    end
    e_stall = 0;
    e_pc = o.v && o.br && (o.z != o.bne);
    @(posedge clk); #1;
    rdv = 32'd0;
    if (acc) begin
      key = int'(sel) * DEPTH + int'((o.a >> 2) % DEPTH);
      w = mm.exists(key) ? mm[key] : 32'hxxxxxxxx;
      if (o.wr) mm[key] = mdl_store(w, o.sz, o.a, o.wd);
      else rdv = mdl_load(w, o.sz, o.uns, o.a);
    end
    e_rd = rdv; e_alu = o.a; e_wreg = o.wreg;
    e_wbc = (o.v && !mis) ? o.wbc : 2'b00;
    e_wbv = o.v; e_mis = mis;
  endtask

  task automatic br_step(input bit v, input bit bne, input bit z, input bit req);
    op_t o;
    o = bop(v, bne, z);
    drive(o);
    #1;
    check("pc_src_literal", {31'd0, pc_s}, {31'd0, req});
    run_op(o);
  endtask

  // Every cycle: compare the selected instance against the model.
  always @(negedge clk) begin
    if (stall_s === 1'b1) stall_cnt++;
    if (wbv_s === 1'b0) bub_cnt++;
    if (chk_en) begin
      check("stall", {31'd0, stall_s}, {31'd0, e_stall});
      check("pc_src", {31'd0, pc_s}, {31'd0, e_pc});
      check("read_data_out", rd_s, e_rd);
      check("alu_result_out", alu_s, e_alu);
      check("write_reg_out", {27'd0, wreg_s}, {27'd0, e_wreg});
      check("wb_control_out", {30'd0, wbc_s}, {30'd0, e_wbc});
      check("wb_valid_out", {31'd0, wbv_s}, {31'd0, e_wbv});
      check("misaligned_out", {31'd0, mis_s}, {31'd0, e_mis});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    op_t o;
    repeat (2) @(posedge clk);
    #1;
    check("reset_wb_valid", {31'd0, wbv_s}, 32'd0);
    check("reset_read_data", rd_s, 32'd0);
    check("reset_alu_result", alu_s, 32'd0);
    check("reset_wb_control", {30'd0, wbc_s}, 32'd0);
    check("reset_misaligned", {31'd0, mis_s}, 32'd0);
    #2 rst_n = 1'b1;

    // Latency 1: word, byte and half accesses, index wrap, read+write collision, branches.
    sel = 2'd0;
    resync();
    stall_cnt = 0;
    run_op(mop(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF));
    run_op(mop(1, 0, 2'd2, 0, 32'h10, 32'd0));
    check("t1_lw", rd_s, 32'hDEADBEEF);
    run_op(mop(0, 1, 2'd0, 0, 32'h11, 32'h0000007F));
    run_op(mop(1, 0, 2'd0, 0, 32'h11, 32'd0));
    check("t2_lb_11", rd_s, 32'h0000007F);
    run_op(mop(1, 0, 2'd0, 0, 32'h13, 32'd0));
    check("t2_lb_13", rd_s, 32'hFFFFFFDE);
    run_op(mop(1, 0, 2'd0, 1, 32'h13, 32'd0));
    check("t2_lbu_13", rd_s, 32'h000000DE);
    run_op(mop(0, 1, 2'd2, 0, 32'h40, 32'h01020304));
    run_op(mop(0, 1, 2'd1, 0, 32'h42, 32'h1234BEEF));
    run_op(mop(1, 0, 2'd1, 1, 32'h42, 32'd0));
    check("lhu_42", rd_s, 32'h0000BEEF);
    run_op(mop(1, 0, 2'd1, 0, 32'h42, 32'd0));
    check("lh_42", rd_s, 32'hFFFFBEEF);
    run_op(mop(1, 0, 2'd0, 1, 32'h40, 32'd0));
    check("lbu_40", rd_s, 32'h00000004);
    run_op(mop(0, 1, 2'd2, 0, 32'h1040, 32'h5A5AA5A5));
    run_op(mop(1, 0, 2'd2, 0, 32'h40, 32'd0));
    check("wrap_lw_40", rd_s, 32'h5A5AA5A5);
    run_op(mop(1, 1, 2'd2, 0, 32'h44, 32'h77665544));
    check("rw_collision_rd", rd_s, 32'd0);
    run_op(mop(1, 0, 2'd2, 0, 32'h44, 32'd0));
    check("rw_collision_store", rd_s, 32'h77665544);
    check("t1_no_stall", stall_cnt, 32'd0);
    br_step(1, 0, 1, 1);
    br_step(1, 1, 1, 0);
    br_step(1, 1, 0, 1);
    br_step(1, 0, 0, 0);
    br_step(0, 0, 1, 0);

    // Latency 3: stall/bubble timing, half loads, misalignment.
    sel = 2'd1;
    resync();
    run_op(mop(0, 1, 2'd2, 0, 32'h00, 32'h80017FFF));
    stall_cnt = 0;
    bub_cnt = 0;
    run_op(mop(1, 0, 2'd2, 0, 32'h00, 32'd0));
    check("t3_stall_cycles", stall_cnt, 32'd2);
    check("t3_bubbles", bub_cnt, 32'd2);
    check("t3_lw", rd_s, 32'h80017FFF);
    run_op(mop(1, 0, 2'd1, 0, 32'h02, 32'd0));
    check("t4_lh_02", rd_s, 32'hFFFF8001);
    run_op(mop(1, 0, 2'd1, 1, 32'h00, 32'd0));
    check("t4_lhu_00", rd_s, 32'h00007FFF);
    run_op(mop(0, 1, 2'd2, 0, 32'h04, 32'h12345678));
    run_op(mop(1, 0, 2'd2, 0, 32'h06, 32'd0));
    check("t4_mis_flag", {31'd0, mis_s}, 32'd1);
    check("t4_mis_wbc", {30'd0, wbc_s}, 32'd0);
    check("t4_mis_valid", {31'd0, wbv_s}, 32'd1);
    run_op(mop(0, 1, 2'd2, 0, 32'h06, 32'hFFFFFFFF));
    run_op(mop(0, 1, 2'd1, 0, 32'h05, 32'h0000FFFF));
    run_op(mop(1, 0, 2'd2, 0, 32'h04, 32'd0));
    check("t4_mem_unchanged", rd_s, 32'h12345678);
    o = mop(1, 0, 2'd0, 1, 32'h07, 32'd0);
    o.br = 1; o.z = 1;
    run_op(o);
    check("lbu_07_with_branch", rd_s, 32'h00000012);

    // Latency 4: reset in the middle of a store.
    sel = 2'd2;
    resync();
    run_op(mop(0, 1, 2'd2, 0, 32'h20, 32'h11223344));
    chk_en = 0;
    drive(mop(0, 1, 2'd2, 0, 32'h20, 32'hCAFEF00D));
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6_mid_access_stall", {31'd0, stall_s}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_alu", alu_s, 32'd0);
    check("t6_rst_wreg", {27'd0, wreg_s}, 32'd0);
    check("t6_rst_read", rd_s, 32'd0);
    check("t6_rst_valid", {31'd0, wbv_s}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    t_v = 0;
    rst_n = 1'b1;
    resync();
    run_op(mop(1, 0, 2'd2, 0, 32'h20, 32'd0));
    check("t6_old_word", rd_s, 32'h11223344);
    chk_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
